// File: rtl/rv_alu_pkg.sv
// rv_alu_pkg: opcode encodings, default width and opcode legality helper
// for the execute-stage integer ALU. Honours `ALU_EXT_OPS_EN.
package rv_alu_pkg;

    localparam int ALU_W = 32;

    typedef enum logic [3:0] {
        OP_AND  = 4'b0000,
        OP_OR   = 4'b0001,
        OP_ADD  = 4'b0010,
        OP_XOR  = 4'b0011,
        OP_SLL  = 4'b0100,
        OP_SRL  = 4'b0101,
        OP_SUB  = 4'b0110,
        OP_SRA  = 4'b0111,
        OP_SLT  = 4'b1000,
        OP_SLTU = 4'b1001
    } alu_op_e;

    // Legal opcodes depend on the build: the extended set is only
    // decodable when the extension is compiled in.
    function automatic logic is_valid_op(alu_op_e op);
        logic v;
        v = 1'b0;
        case (op)
            OP_AND,
            OP_OR,
            OP_ADD,
            OP_SUB:  v = 1'b1;
`ifdef ALU_EXT_OPS_EN
            OP_XOR,
            OP_SLL,
            OP_SRL,
            OP_SRA,
            OP_SLT,
            OP_SLTU: v = 1'b1;
`endif
            default: v = 1'b0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/rv_alu_shifter.sv
// rv_alu_shifter: combinational SLL/SRL/SRA unit.
// Ports: in_a operand, shamt amount, left/arith mode, result.
module rv_alu_shifter
    import rv_alu_pkg::*;
#(
    parameter  int WIDTH = ALU_W,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] in_a,
    input  logic [SHW-1:0]   shamt,
    input  logic             left,
    input  logic             arith,
    output logic [WIDTH-1:0] result
);

    logic             fill;
    logic [WIDTH-1:0] shl;
    logic [WIDTH-1:0] shr;
    logic [WIDTH-1:0] sign_mask;

    always_comb begin
        fill      = arith & in_a[WIDTH-1];
        shl       = in_a << shamt;
        // Bits vacated by the right shift are the ones cleared here.
        sign_mask = ~({WIDTH{1'b1}} >> shamt);
        shr       = (in_a >> shamt) | (fill ? sign_mask : '0);
        result    = left ? shl : shr;
    end

endmodule

// File: rtl/rv_alu.sv
// rv_alu: execute-stage integer ALU. result/zero/overflow are combinational;
// illegal_op is a sticky registered flag. Extended ops via `ALU_EXT_OPS_EN.
module rv_alu
    import rv_alu_pkg::*;
#(
    parameter int WIDTH = ALU_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal_op
);

    localparam int SHW = $clog2(WIDTH);

    alu_op_e op;
    assign op = alu_op_e'(alu_op);

    // Shared adder/subtractor: a + (b ^ {sub}) + sub.
    logic             sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] sum;
    logic             add_ovf;
    logic             is_arith;

    assign sub   = (op == OP_SUB);
    assign b_eff = in_b ^ {WIDTH{sub}};
    assign sum   = in_a + b_eff + {{(WIDTH-1){1'b0}}, sub};

    // Same-sign inputs to the adder producing a different-sign sum;
    // b_eff folds the SUB rule into the ADD rule.
    assign add_ovf  = (in_a[WIDTH-1] == b_eff[WIDTH-1])
                    & (sum[WIDTH-1] != in_a[WIDTH-1]);
    assign is_arith = (op == OP_ADD) | (op == OP_SUB);

`ifdef ALU_EXT_OPS_EN
    logic [WIDTH-1:0] sh_res;
    logic             lt_s;
    logic             lt_u;

    rv_alu_shifter #(
        .WIDTH (WIDTH)
    ) u_shifter (
        .in_a   (in_a),
        .shamt  (in_b[SHW-1:0]),
        .left   (op == OP_SLL),
        .arith  (op == OP_SRA),
        .result (sh_res)
    );

    assign lt_s = $signed(in_a) < $signed(in_b);
    assign lt_u = in_a < in_b;
`endif

    always_comb begin
        result = '0;
        unique case (op)
            OP_AND:  result = in_a & in_b;
            OP_OR:   result = in_a | in_b;
            OP_ADD:  result = sum;
            OP_SUB:  result = sum;
`ifdef ALU_EXT_OPS_EN
            OP_XOR:  result = in_a ^ in_b;
            OP_SLL:  result = sh_res;
            OP_SRL:  result = sh_res;
            OP_SRA:  result = sh_res;
            OP_SLT:  result = {{(WIDTH-1){1'b0}}, lt_s};
            OP_SLTU: result = {{(WIDTH-1){1'b0}}, lt_u};
`endif
            default: result = '0;
        endcase
    end

    assign zero     = (result == '0);
    assign overflow = is_arith & add_ovf;

    // Sticky error flag; reset wins over a same-edge set.
    logic illegal_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else if (!is_valid_op(op)) begin
            illegal_q <= 1'b1;
        end
    end

    assign illegal_op = illegal_q;

endmodule

// File: tb/tb_rv_alu.sv
// tb_rv_alu: self-checking bench for rv_alu, directed vectors plus
// randomized ops against a behavioural model. Honours `ALU_EXT_OPS_EN.
`timescale 1ns/1ps
module tb_rv_alu;

    logic        clk;
    logic        rst_n;
    logic [3:0]  alu_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [31:0] result;
    logic        zero;
    logic        overflow;
    logic        illegal_op;

    int errors = 0;
    int checks = 0;
    logic exp_ill;

    rv_alu #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_op     (alu_op),
        .in_a       (in_a),
        .in_b       (in_b),
        .result     (result),
        .zero       (zero),
        .overflow   (overflow),
        .illegal_op (illegal_op)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit ref_valid(input logic [3:0] op);
        int n;
        n = int'(op);
        if (n == 0 || n == 1 || n == 2 || n == 6) return 1'b1;
`ifdef ALU_EXT_OPS_EN
        if (n == 3 || n == 4 || n == 5 || n == 7 || n == 8 || n == 9)
            return 1'b1;
`endif
        return 1'b0;
    endfunction

    // Returns {overflow, result}, computed with wide signed arithmetic.
    function automatic logic [32:0] ref_model(input logic [3:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] b);
        longint sa, sb, s;
        longint ua, ub;
        int sh;
        logic [31:0] r;
        logic ov;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sh = int'(b % 32);
        r  = 32'd0;
        ov = 1'b0;
        if (ref_valid(op)) begin
            case (int'(op))
                0: r = a & b;
                1: r = a | b;
                2: begin
                    s  = sa + sb;
                    r  = 32'(s);
                    ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                end
                6: begin
                    s  = sa - sb;
                    r  = 32'(s);
                    ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
                end
                3: r = a ^ b;
                4: r = 32'(ua * (64'd1 << sh));
                5: r = 32'(ua / (64'd1 << sh));
                7: r = 32'(sa >>> sh);
                8: r = (sa < sb) ? 32'd1 : 32'd0;
                9: r = (ua < ub) ? 32'd1 : 32'd0;
                default: r = 32'd0;
            endcase
        end
        return {ov, r};
    endfunction

    task automatic apply(input logic [3:0] op,
                         input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        alu_op = op;
        in_a   = a;
        in_b   = b;
        #1;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        alu_op = 4'b1111;
        in_a   = 32'd0;
        in_b   = 32'd0;
        @(posedge clk);
        @(posedge clk);
        #1;
        checks++;
        if (illegal_op !== 1'b0) begin
            errors++;
            $display("FAIL reset_illegal: got %b want 0", illegal_op);
        end
        // Combinational path is live while reset is held.
        apply(4'b0010, 32'd5, 32'd6);
        checks++;
        if (result !== 32'd11) begin
            errors++;
            $display("FAIL reset_comb: got %h want 0000000b", result);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_ill = 1'b0;
    endtask

    task automatic test_directed();
        logic [3:0]  ops[$];
        logic [31:0] as[$];
        logic [31:0] bs[$];
        logic [31:0] rs[$];
        logic        vs[$];
        ops = {4'h0, 4'h1, 4'h2, 4'h2, 4'h2, 4'h2, 4'h2,
               4'h6, 4'h6, 4'h6, 4'h6, 4'h6, 4'h6, 4'hE};
        as  = {32'hFFFFFFFF, 32'h0, 32'd5, 32'hFFFFFFFF, 32'h7FFFFFFF,
               32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, -32'd53512,
               32'h80000000, 32'd555121, 32'h7FFFFFFF, 32'hFFFFFFFF,
               32'd5};
        bs  = {32'h00FF00FF, 32'h0, 32'd6, 32'h190, 32'd1, 32'd1,
               32'hFFFFFFFF, 32'd6, -32'd53513, 32'd1, 32'd555121,
               32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2222};
        rs  = {32'h00FF00FF, 32'h0, 32'd11, 32'h18F, 32'h80000000,
               32'h0, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd1, 32'h7FFFFFFF,
               32'h0, 32'h80000000, 32'h0, 32'h0};
        vs  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
               1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
`ifdef ALU_EXT_OPS_EN
        ops.push_back(4'h7); as.push_back(32'h80000000);
        bs.push_back(32'h24); rs.push_back(32'hF8000000);
        vs.push_back(1'b0);
        ops.push_back(4'h8); as.push_back(32'hFFFFFFFF);
        bs.push_back(32'd1); rs.push_back(32'd1); vs.push_back(1'b0);
        ops.push_back(4'h9); as.push_back(32'hFFFFFFFF);
        bs.push_back(32'd1); rs.push_back(32'd0); vs.push_back(1'b0);
`else
        ops.push_back(4'h3); as.push_back(32'hF0);
        bs.push_back(32'h0F); rs.push_back(32'd0); vs.push_back(1'b0);
`endif
        for (int i = 0; i < ops.size(); i++) begin
            apply(ops[i], as[i], bs[i]);
            checks++;
            if (result !== rs[i]) begin
                errors++;
                $display("FAIL dir%0d_result: op=%h got %h want %h",
                         i, ops[i], result, rs[i]);
            end
            checks++;
            if (zero !== (rs[i] == 32'd0)) begin
                errors++;
                $display("FAIL dir%0d_zero: got %b want %b",
                         i, zero, (rs[i] == 32'd0));
            end
            checks++;
            if (overflow !== vs[i]) begin
                errors++;
                $display("FAIL dir%0d_ovf: got %b want %b",
                         i, overflow, vs[i]);
            end
        end
        @(posedge clk);
        #1;
        exp_ill = 1'b1;
        checks++;
        if (illegal_op !== 1'b1) begin
            errors++;
            $display("FAIL dir_illegal_set: got %b want 1", illegal_op);
        end
    endtask

    task automatic test_sticky();
        rst_n = 1'b0;
        apply(4'h0, 32'd1, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply(4'hE, 32'd5, 32'd2222);
        @(posedge clk);
        #1;
        checks++;
        if (illegal_op !== 1'b1) begin
            errors++;
            $display("FAIL sticky_set: got %b want 1", illegal_op);
        end
        for (int i = 0; i < 3; i++) begin
            apply(4'h2, 32'(i), 32'd7);
            @(posedge clk);
            #1;
            checks++;
            if (illegal_op !== 1'b1) begin
                errors++;
                $display("FAIL sticky_hold%0d: got %b want 1",
                         i, illegal_op);
            end
        end
        // Reset and an invalid op on the same edge: reset wins.
        rst_n = 1'b0;
        apply(4'hF, 32'd0, 32'd0);
        @(posedge clk);
        #1;
        checks++;
        if (illegal_op !== 1'b0) begin
            errors++;
            $display("FAIL sticky_rst_prio: got %b want 0", illegal_op);
        end
        rst_n = 1'b1;
        apply(4'h1, 32'd3, 32'd4);
        @(posedge clk);
        #1;
        checks++;
        if (illegal_op !== 1'b0) begin
            errors++;
            $display("FAIL sticky_stay_clear: got %b want 0", illegal_op);
        end
        exp_ill = 1'b0;
    endtask

    task automatic test_random();
        logic [3:0]  op;
        logic [31:0] a, b;
        logic [32:0] exp;
        logic [31:0] corners[6];
        corners = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF,
                    32'h80000000, 32'h80000001};
        for (int i = 0; i < 400; i++) begin
            op = 4'($urandom_range(0, 15));
            if (i % 40 == 39) op = 4'($urandom_range(10, 15));
            else if (i % 4 == 0) op = 4'($urandom_range(0, 9));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) a = corners[$urandom_range(0, 5)];
            if ($urandom_range(0, 3) == 0) b = corners[$urandom_range(0, 5)];
            if ($urandom_range(0, 7) == 0) b = a;
            // Periodically clear the sticky flag to re-test its set path.
            rst_n = (i % 50 == 0) ? 1'b0 : 1'b1;
            apply(op, a, b);
            exp = ref_model(op, a, b);
            checks++;
            if (result !== exp[31:0] || zero !== (exp[31:0] == 32'd0)
                || overflow !== exp[32]) begin
                errors++;
                $display("FAIL rnd%0d: op=%h a=%h b=%h got r=%h z=%b v=%b want r=%h z=%b v=%b",
                         i, op, a, b, result, zero, overflow,
                         exp[31:0], (exp[31:0] == 32'd0), exp[32]);
            end
            @(posedge clk);
            #1;
            if (!rst_n) exp_ill = 1'b0;
            else if (!ref_valid(op)) exp_ill = 1'b1;
            checks++;
            if (illegal_op !== exp_ill) begin
                errors++;
                $display("FAIL rnd%0d_illegal: op=%h got %b want %b",
                         i, op, illegal_op, exp_ill);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_sticky();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
